// File: rtl/matvec_pkg.sv
// Shared state encoding, accumulator sizing and saturation bounds for matvec_seq.
package matvec_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_MAC  = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    localparam int unsigned WIDE_W = 256;
    typedef logic signed [WIDE_W-1:0] wide_t;

    // Address width for n entries; never zero so single-entry ports stay legal.
    function automatic int unsigned addr_w(input int unsigned n);
        if (n > 32'd1) return 32'($clog2(n));
        return 32'd1;
    endfunction

    // Full-precision accumulator: W x W product plus growth for the column sum.
    function automatic int unsigned acc_width(input int unsigned w, input int unsigned cols);
        return 32'(2 * w) + 32'($clog2(cols));
    endfunction

    function automatic wide_t sat_hi(input int unsigned w);
        return (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    endfunction

    function automatic wide_t sat_lo(input int unsigned w);
        return -(wide_t'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fxp_mac.sv
// Signed fixed-point multiply-accumulate with arithmetic shift and saturation to W bits.
module fxp_mac
    import matvec_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned FRAC  = 16,
    parameter int unsigned ACC_W = 66
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_en,
    input  logic                i_clr,
    input  logic signed [W-1:0] i_a,
    input  logic signed [W-1:0] i_b,
    output logic signed [W-1:0] o_res_c,
    output logic                o_sat_c
);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_hi(W));
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_lo(W));

    logic signed [2*W-1:0]   w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_shift;
    logic signed [ACC_W-1:0] r_acc;
    logic                    w_ovf_hi;
    logic                    w_ovf_lo;

    assign w_prod     = (2*W)'(i_a) * (2*W)'(i_b);
    assign w_prod_ext = ACC_W'(w_prod);

    // First product of a row replaces the running sum instead of adding to it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= i_clr ? w_prod_ext : (r_acc + w_prod_ext);
        end
    end

    assign w_shift  = r_acc >>> FRAC;
    assign w_ovf_hi = (w_shift > SAT_HI);
    assign w_ovf_lo = (w_shift < SAT_LO);
    assign o_sat_c  = w_ovf_hi | w_ovf_lo;
    assign o_res_c  = w_ovf_hi ? W'(SAT_HI) : (w_ovf_lo ? W'(SAT_LO) : W'(w_shift));

endmodule

// File: rtl/matvec_seq.sv
// Sequential fixed-point matrix-vector multiplier: buffer a COLS-element vector,
// then stream the ROWS results of M*x one row at a time with ready/valid.
module matvec_seq
    import matvec_pkg::*;
#(
    parameter int unsigned ROWS = 3,
    parameter int unsigned COLS = 3,
    parameter int unsigned W    = 32,
    parameter int unsigned FRAC = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    w_en,
    input  logic [addr_w(ROWS)-1:0] w_row,
    input  logic [addr_w(COLS)-1:0] w_col,
    input  logic [W-1:0]            w_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [W-1:0]            in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [W-1:0]            out_data,
    output logic                    out_last,
    output logic                    out_sat,
    output logic                    busy
);
    localparam int unsigned RW    = addr_w(ROWS);
    localparam int unsigned CW    = addr_w(COLS);
    localparam int unsigned N     = ROWS * COLS;
    localparam int unsigned MW    = addr_w(N);
    localparam int unsigned ACC_W = acc_width(W, COLS);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    state_e          r_state;
    state_e          w_state_nxt;
    logic [RW-1:0]   r_row_cnt;
    logic [RW-1:0]   w_row_cnt_nxt;
    logic [CW-1:0]   r_col_cnt;
    logic [CW-1:0]   w_col_cnt_nxt;
    logic            w_in_acc;
    logic            w_mac_en;
    logic            w_mac_clr;
    logic            w_out_load;
    logic            w_out_acc;

    logic            r_in_ready;
    logic            r_busy;
    logic            r_out_valid;
    logic [W-1:0]    r_out_data;
    logic            r_out_sat;
    logic            r_out_last;

    logic [W-1:0]    r_mat [N];
    logic [W-1:0]    r_vec [COLS];
    logic [31:0]     w_wr_idx;
    logic [MW-1:0]   w_rd_idx;
    logic            w_wr_ok;
    logic signed [W-1:0] w_res;
    logic            w_sat;

    assign w_wr_idx = 32'(w_row) * COLS + 32'(w_col);
    assign w_wr_ok  = w_en && !r_busy && (32'(w_row) < ROWS) && (32'(w_col) < COLS);
    assign w_rd_idx = MW'(32'(r_row_cnt) * COLS + 32'(r_col_cnt));

    // Storage survives reset; only a reset cycle itself blocks writes.
    always_ff @(posedge clk) begin
        if (!rst && w_wr_ok) begin
            r_mat[MW'(w_wr_idx)] <= w_data;
        end
        if (!rst && w_in_acc) begin
            r_vec[r_col_cnt] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_row_cnt_nxt = r_row_cnt;
        w_col_cnt_nxt = r_col_cnt;
        w_in_acc      = 1'b0;
        w_mac_en      = 1'b0;
        w_mac_clr     = 1'b0;
        w_out_load    = 1'b0;
        w_out_acc     = 1'b0;
        case (r_state)
            S_IDLE, S_LOAD: begin
                if (in_valid && r_in_ready) begin
                    w_in_acc = 1'b1;
                    if (r_col_cnt == COL_LAST) begin
                        w_state_nxt   = S_MAC;
                        w_col_cnt_nxt = '0;
                        w_row_cnt_nxt = '0;
                    end else begin
                        w_state_nxt   = S_LOAD;
                        w_col_cnt_nxt = r_col_cnt + CW'(1);
                    end
                end
            end
            S_MAC: begin
                w_mac_en  = 1'b1;
                w_mac_clr = (r_col_cnt == '0);
                if (r_col_cnt == COL_LAST) begin
                    w_state_nxt   = S_OUT;
                    w_col_cnt_nxt = '0;
                end else begin
                    w_col_cnt_nxt = r_col_cnt + CW'(1);
                end
            end
            S_OUT: begin
                // One cycle to register the result, then hold until accepted.
                if (!r_out_valid) begin
                    w_out_load = 1'b1;
                end else if (out_ready) begin
                    w_out_acc = 1'b1;
                    if (r_row_cnt == ROW_LAST) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt   = S_MAC;
                        w_row_cnt_nxt = r_row_cnt + RW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_cnt   <= '0;
            r_col_cnt   <= '0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            r_row_cnt  <= w_row_cnt_nxt;
            r_col_cnt  <= w_col_cnt_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_in_ready <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
            if (w_out_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_res;
                r_out_sat   <= w_sat;
                r_out_last  <= (r_row_cnt == ROW_LAST);
            end else if (w_out_acc) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    fxp_mac #(
        .W     (W),
        .FRAC  (FRAC),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk     (clk),
        .rst     (rst),
        .i_en    (w_mac_en),
        .i_clr   (w_mac_clr),
        .i_a     (r_mat[w_rd_idx]),
        .i_b     (r_vec[r_col_cnt]),
        .o_res_c (w_res),
        .o_sat_c (w_sat)
    );

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sat   = r_out_sat;
    assign out_last  = r_out_last;

endmodule

// File: tb/tb_matvec_seq.sv
// Directed self-checking bench for matvec_seq at ROWS=COLS=3, W=32, FRAC=16.
module tb_matvec_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_en = 1'b0;
    logic [1:0]  w_row = '0;
    logic [1:0]  w_col = '0;
    logic [31:0] w_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_sat;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] mat [9];

    always #5 clk = ~clk;

    matvec_seq #(.ROWS(3), .COLS(3), .W(32), .FRAC(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .w_en      (w_en),
        .w_row     (w_row),
        .w_col     (w_col),
        .w_data    (w_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    task automatic load_matrix();
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                w_en = 1'b1; w_row = 2'(r); w_col = 2'(c); w_data = mat[r*3+c];
                @(posedge clk); #1;
            end
        end
        w_en = 1'b0;
    endtask

    task automatic set_ident(input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        for (int i = 0; i < 9; i++) mat[i] = 32'h0;
        mat[0] = d0; mat[4] = d1; mat[8] = d2;
    endtask

    // Streams three elements; optionally fires a matrix write alongside the first one.
    task automatic send_vector(input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
                               input logic we, input logic [1:0] wr, input logic [1:0] wc,
                               input logic [31:0] wd, output int ok);
        int t;
        ok = 1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = (k == 0) ? x0 : ((k == 1) ? x1 : x2);
            if (k == 0 && we) begin
                w_en = 1'b1; w_row = wr; w_col = wc; w_data = wd;
            end
            t = 0;
            while (!in_ready && t < 100) begin @(posedge clk); #1; t++; end
            if (!in_ready) ok = 0;
            @(posedge clk); #1;
            w_en = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    // Waits for a result, captures it, and accepts it; lat = edges waited or -1 on timeout.
    task automatic get_row(output logic [31:0] d, output logic s, output logic l, output int lat);
        lat = 0;
        out_ready = 1'b1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        d = out_data; s = out_sat; l = out_last;
        if (!out_valid) lat = -1;
        else begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_data = 32'h1234; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0; in_valid = 1'b0;
        n_vec++; if (busy !== 1'b0)           begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_vec++; if (out_valid !== 1'b0)      begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1)       begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_vec++; if (out_data !== 32'h0)      begin n_err++; $display("FAIL reset_out_data: got %h expected 00000000", out_data); end
        n_vec++; if (out_sat !== 1'b0)        begin n_err++; $display("FAIL reset_out_sat: got %b expected 0", out_sat); end
        n_vec++; if (out_last !== 1'b0)       begin n_err++; $display("FAIL reset_out_last: got %b expected 0", out_last); end
    endtask

    task automatic test_identity();
        logic [31:0] expv [3];
        logic [31:0] d; logic s, l; int lat, ok;
        expv[0] = 32'h0001_0000; expv[1] = 32'h0002_0000; expv[2] = 32'h0003_0000;
        set_ident(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        load_matrix();
        send_vector(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b0, 2'd0, 2'd0, 32'h0, ok);
        n_vec++; if (ok != 1) begin n_err++; $display("FAIL ident_accept: got %0d expected 1", ok); end
        for (int r = 0; r < 3; r++) begin
            get_row(d, s, l, lat);
            n_vec++; if (lat < 0 || d !== expv[r]) begin n_err++; $display("FAIL ident_data row%0d: got %h expected %h (lat %0d)", r, d, expv[r], lat); end
            n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL ident_sat row%0d: got %b expected 0", r, s); end
            n_vec++; if (l !== (r == 2)) begin n_err++; $display("FAIL ident_last row%0d: got %b expected %b", r, l, (r == 2)); end
        end
    endtask

    task automatic test_scaled();
        logic [31:0] d; logic s, l; int lat, ok;
        for (int i = 0; i < 9; i++) mat[i] = 32'h0002_0000;
        load_matrix();
        send_vector(32'h0001_8000, 32'h0001_8000, 32'h0001_8000, 1'b0, 2'd0, 2'd0, 32'h0, ok);
        for (int r = 0; r < 3; r++) begin
            get_row(d, s, l, lat);
            if (r == 0) begin
                n_vec++; if (lat != 4) begin n_err++; $display("FAIL scaled_latency: got %0d edges expected 4", lat); end
            end
            n_vec++; if (lat < 0 || d !== 32'h0009_0000) begin n_err++; $display("FAIL scaled_data row%0d: got %h expected 00090000", r, d); end
        end
    endtask

    task automatic test_negative();
        logic [31:0] expv [3];
        logic [31:0] d; logic s, l; int lat, ok;
        for (int i = 0; i < 9; i++) mat[i] = 32'h0;
        mat[0] = 32'hFFFE_0000; mat[5] = 32'h0001_0000; mat[6] = 32'hFFFF_FFFF;
        expv[0] = 32'hFFFD_0000; expv[1] = 32'h0005_0000; expv[2] = 32'hFFFF_FFFE;
        load_matrix();
        send_vector(32'h0001_8000, 32'h0000_0007, 32'h0005_0000, 1'b0, 2'd0, 2'd0, 32'h0, ok);
        for (int r = 0; r < 3; r++) begin
            get_row(d, s, l, lat);
            n_vec++; if (lat < 0 || d !== expv[r]) begin n_err++; $display("FAIL neg_data row%0d: got %h expected %h", r, d, expv[r]); end
            n_vec++; if (s !== 1'b0) begin n_err++; $display("FAIL neg_sat row%0d: got %b expected 0", r, s); end
        end
    endtask

    task automatic test_saturation();
        logic [31:0] d; logic s, l; int lat, ok;
        for (int i = 0; i < 9; i++) mat[i] = 32'h7FFF_0000;
        load_matrix();
        send_vector(32'h7FFF_0000, 32'h7FFF_0000, 32'h7FFF_0000, 1'b0, 2'd0, 2'd0, 32'h0, ok);
        for (int r = 0; r < 3; r++) begin
            get_row(d, s, l, lat);
            n_vec++; if (lat < 0 || d !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL satpos_data row%0d: got %h expected 7fffffff", r, d); end
            n_vec++; if (s !== 1'b1) begin n_err++; $display("FAIL satpos_flag row%0d: got %b expected 1", r, s); end
        end
        send_vector(32'h8001_0000, 32'h8001_0000, 32'h8001_0000, 1'b0, 2'd0, 2'd0, 32'h0, ok);
        for (int r = 0; r < 3; r++) begin
            get_row(d, s, l, lat);
            n_vec++; if (lat < 0 || d !== 32'h8000_0000) begin n_err++; $display("FAIL satneg_data row%0d: got %h expected 80000000", r, d); end
            n_vec++; if (s !== 1'b1) begin n_err++; $display("FAIL satneg_flag row%0d: got %b expected 1", r, s); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d; logic s, l; int lat, ok, t;
        set_ident(32'h0001_0000, 32'h0001_0000, 32'h0001_0000);
        load_matrix();
        send_vector(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b0, 2'd0, 2'd0, 32'h0, ok);
        get_row(d, s, l, lat);
        n_vec++; if (lat < 0 || d !== 32'h0001_0000) begin n_err++; $display("FAIL bp_row0: got %h expected 00010000", d); end
        out_ready = 1'b0;
        t = 0;
        while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin w_en = 1'b1; w_row = 2'd0; w_col = 2'd0; w_data = 32'h0005_0000; end
            @(posedge clk); #1;
            w_en = 1'b0;
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== 32'h0002_0000 || out_last !== 1'b0) begin
                n_err++; $display("FAIL bp_hold cycle%0d: got valid %b data %h last %b expected 1 00020000 0", i, out_valid, out_data, out_last);
            end
        end
        get_row(d, s, l, lat);
        n_vec++; if (lat != 0 || d !== 32'h0002_0000) begin n_err++; $display("FAIL bp_row1: got %h lat %0d expected 00020000 lat 0", d, lat); end
        get_row(d, s, l, lat);
        n_vec++; if (lat < 0 || d !== 32'h0003_0000 || l !== 1'b1) begin n_err++; $display("FAIL bp_row2: got %h last %b expected 00030000 1", d, l); end
        // Busy-time write must be dropped; the IDLE write alongside element 0 must land.
        send_vector(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b1, 2'd2, 2'd2, 32'h0002_0000, ok);
        get_row(d, s, l, lat);
        n_vec++; if (lat < 0 || d !== 32'h0001_0000) begin n_err++; $display("FAIL busy_write_ignored: got %h expected 00010000", d); end
        get_row(d, s, l, lat);
        n_vec++; if (lat < 0 || d !== 32'h0002_0000) begin n_err++; $display("FAIL idle_write_row1: got %h expected 00020000", d); end
        get_row(d, s, l, lat);
        n_vec++; if (lat < 0 || d !== 32'h0006_0000) begin n_err++; $display("FAIL idle_write_row2: got %h expected 00060000", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] expv [3];
        logic [31:0] d; logic s, l; int lat, ok, seen;
        expv[0] = 32'h0003_0000; expv[1] = 32'h0001_0000; expv[2] = 32'h0004_0000;
        out_ready = 1'b1;
        send_vector(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 1'b0, 2'd0, 2'd0, 32'h0, ok);
        @(posedge clk); #1;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_busy_before: got %b expected 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy_after: got %b expected 0", busy); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid_after: got %b expected 0", out_valid); end
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready_after: got %b expected 1", in_ready); end
        seen = 0;
        for (int i = 0; i < 10; i++) begin @(posedge clk); #1; if (out_valid === 1'b1) seen++; end
        n_vec++; if (seen != 0) begin n_err++; $display("FAIL mid_no_output: got %0d valid cycles expected 0", seen); end
        send_vector(32'h0003_0000, 32'h0001_0000, 32'h0002_0000, 1'b0, 2'd0, 2'd0, 32'h0, ok);
        for (int r = 0; r < 3; r++) begin
            get_row(d, s, l, lat);
            n_vec++; if (lat < 0 || d !== expv[r]) begin n_err++; $display("FAIL mid_retained row%0d: got %h expected %h", r, d, expv[r]); end
        end
    endtask

    initial begin
        test_reset();
        test_identity();
        test_scaled();
        test_negative();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
